// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO responder for the multi-cycle CPU's MIO bus.
// Decodes addr[31:28] into RAM (0x0), GPIO (0xE), free-running counter (0xF)
// or unmapped space, inserts RAM wait states and returns a one-cycle
// registered mio_ready pulse followed by a mandatory GAP cycle.
// Optional feature macro: MIO_ERR_EN (sticky bus_err flag plus an error
// status register at 0xF000_0004). Without it bus_err is tied low and the
// whole 0xF region maps to the counter.
module mio_bus_responder #(
    parameter int RAM_LATENCY = 2,
    parameter int RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_from_cpu,
    output logic [31:0]       data_to_cpu,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [31:0]       gpio_in,
    output logic [31:0]       gpio_out,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_RESP     = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    localparam logic [3:0] LP_RAM_LAT = 4'(RAM_LATENCY);

    state_t            r_state;
    logic [3:0]        r_wait;
    logic              r_is_read;
    logic [31:0]       r_data_to_cpu;
    logic              r_mio_ready;
    logic [RAM_AW-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [31:0]       r_ram_din;
    logic [31:0]       r_gpio_out;
    logic [31:0]       r_counter;

    state_t            w_state_nx;
    logic [3:0]        w_wait_nx;
    logic              w_is_read_nx;
    logic [31:0]       w_data_nx;
    logic              w_ready_nx;
    logic [RAM_AW-1:0] w_ram_addr_nx;
    logic              w_ram_we_nx;
    logic [31:0]       w_ram_din_nx;
    logic [31:0]       w_gpio_nx;
    logic [31:0]       w_counter_nx;

    // Address decode; a simultaneous read+write is illegal and falls into unmapped.
    logic w_req;
    logic w_legal;
    logic w_sel_ram;
    logic w_sel_gpio;
    logic w_sel_cnt;
    logic w_unused_ok;

    assign w_req       = cpu_mio & (mem_r | mem_w);
    assign w_legal     = ~(mem_r & mem_w);
    assign w_sel_ram   = w_legal & (addr[31:28] == 4'h0);
    assign w_sel_gpio  = w_legal & (addr[31:28] == 4'hE);
    assign w_unused_ok = &{1'b0, addr};

`ifdef MIO_ERR_EN
    logic r_bus_err;
    logic w_err_nx;
    logic w_sel_err;
    assign w_sel_cnt = w_legal & (addr[31:28] == 4'hF) & ~addr[2];
    assign w_sel_err = w_legal & (addr[31:28] == 4'hF) &  addr[2];
    assign bus_err   = r_bus_err;
`else
    assign w_sel_cnt = w_legal & (addr[31:28] == 4'hF);
    assign bus_err   = 1'b0;
`endif

    // Next-state and next-register-value logic for the request FSM.
    always_comb begin
        w_state_nx    = r_state;
        w_wait_nx     = r_wait;
        w_is_read_nx  = r_is_read;
        w_data_nx     = r_data_to_cpu;
        w_ready_nx    = 1'b0;
        w_ram_addr_nx = r_ram_addr;
        w_ram_we_nx   = 1'b0;
        w_ram_din_nx  = r_ram_din;
        w_gpio_nx     = r_gpio_out;
        w_counter_nx  = r_counter + 32'd1;
`ifdef MIO_ERR_EN
        w_err_nx      = r_bus_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_sel_ram) begin
                        w_ram_addr_nx = addr[RAM_AW+1:2];
                        w_ram_din_nx  = data_from_cpu;
                        w_is_read_nx  = mem_r;
                        if (mem_w) begin
                            w_ram_we_nx = 1'b1;
                            w_wait_nx   = 4'd1;
                        end else begin
                            w_wait_nx   = LP_RAM_LAT;
                        end
                        w_state_nx = ST_RAM_WAIT;
                    end else begin
                        // Peripheral and unmapped accesses complete at this edge.
                        w_ready_nx = 1'b1;
                        w_state_nx = ST_RESP;
                        if (w_sel_gpio) begin
                            if (mem_r) begin
                                w_data_nx = gpio_in;
                            end else begin
                                w_gpio_nx = data_from_cpu;
                            end
                        end else if (w_sel_cnt) begin
                            if (mem_r) begin
                                w_data_nx = r_counter;
                            end else begin
                                w_counter_nx = data_from_cpu;
                            end
`ifdef MIO_ERR_EN
                        end else if (w_sel_err) begin
                            if (mem_r) begin
                                w_data_nx = {31'd0, r_bus_err};
                            end else begin
                                w_err_nx = 1'b0;
                            end
`endif
                        end else begin
                            // Unmapped or illegal: reads return zero, writes vanish.
                            if (mem_r) begin
                                w_data_nx = 32'h0000_0000;
                            end else begin
                                w_data_nx = r_data_to_cpu;
                            end
`ifdef MIO_ERR_EN
                            w_err_nx = 1'b1;
`endif
                        end
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RAM_WAIT: begin
                // Completes regardless of whether the CPU still holds the request.
                if (r_wait == 4'd1) begin
                    if (r_is_read) begin
                        w_data_nx = ram_dout;
                    end else begin
                        w_data_nx = r_data_to_cpu;
                    end
                    w_ready_nx = 1'b1;
                    w_state_nx = ST_RESP;
                end else begin
                    w_wait_nx = r_wait - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nx = ST_GAP;
            end
            ST_GAP: begin
                // Absorbs the CPU's one-cycle request deassert lag.
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wait        <= 4'd0;
            r_is_read     <= 1'b0;
            r_data_to_cpu <= 32'h0000_0000;
            r_mio_ready   <= 1'b0;
            r_ram_addr    <= {RAM_AW{1'b0}};
            r_ram_we      <= 1'b0;
            r_ram_din     <= 32'h0000_0000;
            r_gpio_out    <= 32'h0000_0000;
            r_counter     <= 32'h0000_0000;
        end else begin
            r_state       <= w_state_nx;
            r_wait        <= w_wait_nx;
            r_is_read     <= w_is_read_nx;
            r_data_to_cpu <= w_data_nx;
            r_mio_ready   <= w_ready_nx;
            r_ram_addr    <= w_ram_addr_nx;
            r_ram_we      <= w_ram_we_nx;
            r_ram_din     <= w_ram_din_nx;
            r_gpio_out    <= w_gpio_nx;
            r_counter     <= w_counter_nx;
        end
    end

`ifdef MIO_ERR_EN
    // Sticky error flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_err_nx;
        end
    end
`endif

    assign data_to_cpu = r_data_to_cpu;
    assign mio_ready   = r_mio_ready;
    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_din     = r_ram_din;
    assign gpio_out    = r_gpio_out;

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
Memory/IO-side responder for the multi-cycle CPU's MIO bus. It accepts read and write requests qualified by cpu_mio, decodes the address into RAM, a GPIO register, a free-running counter, or an unmapped region. It inserts wait states for RAM and returns read data together with a one-cycle mio_ready pulse. It sits between the CPU controller/datapath and the block RAM and peripherals.

Parameters:
RAM_LATENCY, 2, RAM read wait cycles from ram_addr valid to ram_dout valid; legal range 1..15
RAM_AW, 10, RAM word-address width; ram_addr = addr[RAM_AW+1:2]

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
cpu_mio  input  1  request qualifier from CPU
mem_r  input  1  read request
mem_w  input  1  write request
addr  input  32  byte address; bits [1:0] ignored
data_from_cpu  input  32  write data
data_to_cpu  output  32  read data, registered
mio_ready  output  1  one-cycle completion pulse, registered
ram_addr  output  RAM_AW  RAM word address
ram_we  output  1  RAM write enable
ram_din  output  32  RAM write data
ram_dout  input  32  RAM read data
gpio_in  input  32  switch/button inputs
gpio_out  output  32  GPIO output register
bus_err  output  1  sticky error flag; see Optional Feature

Behaviour:
- Reset (async) values: state=IDLE; mio_ready=0; data_to_cpu=0; ram_we=0; ram_addr=0; ram_din=0; gpio_out=0; counter=0; bus_err=0.
- Request valid = cpu_mio & (mem_r | mem_w), sampled in IDLE only. The CPU holds the request until it samples mio_ready=1.
- Address map, decoded on addr[31:28]:
  - 0x0 = RAM.
  - 0xE = GPIO. Read returns gpio_in; write loads gpio_out.
  - 0xF = counter. Read returns counter; write loads counter.
  - Any other value = unmapped.
- mem_r & mem_w both high = illegal. It is treated as unmapped.
- States: IDLE, RAM_WAIT, RESP, GAP.
- IDLE, no request: remain in IDLE.
- IDLE, RAM request:
  - Latch ram_addr and ram_din.
  - Write: ram_we=1 for exactly the next cycle only.
  - Load the wait counter with RAM_LATENCY (read) or 1 (write).
  - Go to RAM_WAIT.
- IDLE, GPIO/counter/unmapped request: perform the access at this edge and go to RESP.
- RAM_WAIT: decrement the wait counter each cycle. When it reaches 1, capture ram_dout into data_to_cpu (reads only) and go to RESP.
- RESP: mio_ready=1 for exactly this one cycle, then go to GAP.
- GAP: mio_ready=0 for one mandatory idle cycle, during which any request is ignored; then go to IDLE. This absorbs the CPU's one-cycle request deassert lag.
- Read latency, request-visible cycle to mio_ready:
  - Peripheral/unmapped: 1 cycle.
  - RAM read: RAM_LATENCY+1 cycles.
  - RAM write: 2 cycles.
- data_to_cpu:
  - Updates only on read completion.
  - Holds its value across writes and idle cycles.
  - Unmapped read returns 0x0000_0000.
- Unmapped write: dropped, with no side effects.
- Counter:
  - Free-running, +1 every cycle, wrapping 0xFFFF_FFFF to 0.
  - A CPU write in the same cycle takes precedence; the loaded value appears next cycle, then increments.
  - A read returns the value at the sampling edge.
- Request dropped mid-RAM_WAIT (CPU protocol violation): the access still completes and mio_ready still pulses.
- Reset mid-operation: immediate return to reset values. A pending ram_we is cancelled.

Optional Feature:
Macro MIO_ERR_EN.
- Defined:
  - bus_err sets on any unmapped or illegal (mem_r&mem_w) request and stays set until reset or until a write to 0xF000_0004.
  - A read of 0xF000_0004 returns {31'b0, bus_err}.
  - Counter decode becomes addr[31:28]==0xF with addr[2]==0; addr[2]==1 selects the error status register.
- Not defined:
  - bus_err is tied 0.
  - The whole 0xF region maps to the counter.

Test Plan:
- Reset: assert reset mid-RAM_WAIT -> all outputs return to reset values immediately; no mio_ready pulse follows.
- RAM write then read (RAM_LATENCY=2):
  - Write 0xDEADBEEF to 0x0000_0010 -> ram_we=1 for one cycle with ram_addr=4 and ram_din=0xDEADBEEF; mio_ready 2 cycles after the request.
  - Read back -> data_to_cpu=0xDEADBEEF, mio_ready 3 cycles after the request.
- GPIO:
  - Write 0x0000_00A5 to 0xE000_0000 -> gpio_out=0x0000_00A5 next cycle.
  - gpio_in=0x1234_5678, read 0xE000_0000 -> data_to_cpu=0x1234_5678 with mio_ready after 1 cycle.
- Counter: write 0xFFFF_FFFE to 0xF000_0000, then read 3 cycles later -> value reflects wrap (0x0000_0001 or exact cycle-count value); verify load-over-increment precedence.
- Unmapped/illegal:
  - Read 0x5000_0000 -> data_to_cpu=0, mio_ready after 1 cycle.
  - With MIO_ERR_EN: bus_err=1; read 0xF000_0004 returns 1; write 0xF000_0004 clears it.
- Back-to-back: hold the request through mio_ready and GAP -> exactly one mio_ready per transaction; the next request is accepted only in IDLE after GAP.
